// File: rtl/msg_pkg.sv
// msg_pkg: frame constants and state encoding shared by the message link receive and transmit paths
package msg_pkg;
    localparam logic [7:0] HDR_WR  = 8'h5A;
    localparam logic [7:0] HDR_RD  = 8'h5B;
    localparam logic [7:0] TAIL_WR = 8'hA5;
    localparam logic [7:0] TAIL_RD = 8'hA4;
    typedef enum logic [2:0] {HUNT, ADDR, DATA, TAIL, EXEC, DONE, ERROR} state_t;
    function automatic logic [7:0] tail_of(input logic rd);
        return rd ? TAIL_RD : TAIL_WR;
    endfunction
endpackage

// File: rtl/msg_byte_fetch.sv
// msg_byte_fetch: issues one-cycle FIFO reads and presents each returned byte as a strobe
module msg_byte_fetch (
    input  logic       OPB_CLK,
    input  logic       OPB_RST,
    input  logic       en,
    input  logic       RX_FIFO_EMPTY,
    input  logic [7:0] RX_FIFO_DATA,
    output logic       RX_FIFO_RD,
    output logic       byte_stb,
    output logic [7:0] byte_data
);
    // the read strobe doubles as the pending flag, limiting the rate to one byte per two cycles
    always_ff @(posedge OPB_CLK or posedge OPB_RST)
        if (OPB_RST) begin
            RX_FIFO_RD <= 1'b0;
            byte_stb   <= 1'b0;
        end else begin
            RX_FIFO_RD <= en && !RX_FIFO_EMPTY && !RX_FIFO_RD;
            byte_stb   <= RX_FIFO_RD;
        end
    assign byte_data = RX_FIFO_DATA;
endmodule

// File: rtl/msg_read.sv
// msg_read: parses 10-byte frames from the RX FIFO and runs them as OPB master writes or reads
import msg_pkg::*;
module msg_read #(
    parameter logic [15:0] BYTE_TIMEOUT = 16'd200,
    parameter logic [15:0] ACK_TIMEOUT  = 16'd1024
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST,
    input  logic        PULSE_2KHZ,
    output logic        RX_FIFO_RD,
    input  logic [7:0]  RX_FIFO_DATA,
    input  logic        RX_FIFO_EMPTY,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_DO,
    input  logic [31:0] M_DI,
    output logic        M_WE,
    output logic        M_RE,
    input  logic        M_XFERACK,
    output logic        RSP_VALID,
    output logic [31:0] RSP_ADDR,
    output logic [31:0] RSP_DATA,
    output logic        FRAME_OK,
    output logic        ERROR_FLAG,
    output logic [7:0]  ERR_CNT
);
    state_t      state, next_state;
    logic        byte_stb, op_rd, fetch_en, byte_to, ack_to, in_frame;
    logic [7:0]  byte_data;
    logic [1:0]  cnt;
    logic [31:0] addr, data;
    logic [15:0] byte_tmr, ack_tmr;
    // fetch enable looks at next_state so no read is ever issued while in EXEC/DONE/ERROR
    assign fetch_en = next_state inside {HUNT, ADDR, DATA, TAIL};
    assign in_frame = state inside {ADDR, DATA, TAIL};
    assign byte_to  = PULSE_2KHZ && byte_tmr == BYTE_TIMEOUT - 16'd1 && !byte_stb;
    assign ack_to   = ack_tmr == ACK_TIMEOUT - 16'd1;
    assign FRAME_OK   = state == DONE;
    assign ERROR_FLAG = state == ERROR;
    msg_byte_fetch u_fetch (
        .OPB_CLK      (OPB_CLK),
        .OPB_RST      (OPB_RST),
        .en           (fetch_en),
        .RX_FIFO_EMPTY(RX_FIFO_EMPTY),
        .RX_FIFO_DATA (RX_FIFO_DATA),
        .RX_FIFO_RD   (RX_FIFO_RD),
        .byte_stb     (byte_stb),
        .byte_data    (byte_data)
    );
    always_ff @(posedge OPB_CLK or posedge OPB_RST)
        if (OPB_RST) state <= HUNT;
        else state <= next_state;
    always_comb begin
        next_state = state;
        case (state)
            HUNT:  next_state = byte_stb && (byte_data == HDR_WR || byte_data == HDR_RD) ? ADDR : HUNT;
            ADDR:  next_state = byte_stb ? (cnt == 2'd3 ? DATA : ADDR) : byte_to ? ERROR : ADDR;
            DATA:  next_state = byte_stb ? (cnt == 2'd3 ? TAIL : DATA) : byte_to ? ERROR : DATA;
            TAIL:  next_state = byte_stb ? (byte_data == tail_of(op_rd) ? EXEC : ERROR) : byte_to ? ERROR : TAIL;
            EXEC:  next_state = M_XFERACK ? DONE : ack_to ? ERROR : EXEC;
            default: next_state = HUNT;
        endcase
    end
    always_ff @(posedge OPB_CLK or posedge OPB_RST)
        if (OPB_RST) begin
            op_rd     <= 1'b0;
            cnt       <= 2'd0;
            addr      <= '0;
            data      <= '0;
            byte_tmr  <= '0;
            ack_tmr   <= '0;
            M_ADDR    <= '0;
            M_DO      <= '0;
            M_WE      <= 1'b0;
            M_RE      <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_ADDR  <= '0;
            RSP_DATA  <= '0;
            ERR_CNT   <= '0;
        end else begin
            RSP_VALID <= 1'b0;
            if (state == HUNT && byte_stb) op_rd <= byte_data == HDR_RD;
            cnt <= state == HUNT ? 2'd0 : byte_stb && (state == ADDR || state == DATA) ? cnt + 2'd1 : cnt;
            if (state == ADDR && byte_stb) addr <= {addr[23:0], byte_data};
            if (state == DATA && byte_stb) data <= {data[23:0], byte_data};
            byte_tmr <= byte_stb || !in_frame ? 16'd0 : PULSE_2KHZ ? byte_tmr + 16'd1 : byte_tmr;
            ack_tmr  <= state == EXEC ? ack_tmr + 16'd1 : 16'd0;
            if (state == TAIL && next_state == EXEC) begin
                M_ADDR <= addr;
                if (!op_rd) M_DO <= data;
                M_WE <= !op_rd;
                M_RE <= op_rd;
            end
            if (state == EXEC && next_state != EXEC) begin
                M_WE <= 1'b0;
                M_RE <= 1'b0;
            end
            if (state == EXEC && M_XFERACK && op_rd) begin
                RSP_VALID <= 1'b1;
                RSP_ADDR  <= addr;
                RSP_DATA  <= M_DI;
            end
            if (state == ERROR && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
        end
endmodule

// File: tb/tb_msg_read.sv
// tb_msg_read: directed frame vectors plus timeout and reset sequences for msg_read
module tb_msg_read;
    logic        OPB_CLK = 1'b0, OPB_RST = 1'b1, PULSE_2KHZ = 1'b0;
    logic        RX_FIFO_RD, RX_FIFO_EMPTY = 1'b1, M_WE, M_RE, M_XFERACK = 1'b0;
    logic        RSP_VALID, FRAME_OK, ERROR_FLAG;
    logic [7:0]  RX_FIFO_DATA = 8'h00, ERR_CNT;
    logic [31:0] M_ADDR, M_DO, M_DI = 32'h0, RSP_ADDR, RSP_DATA;

    always #5 OPB_CLK = ~OPB_CLK;

    msg_read dut (
        .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST), .PULSE_2KHZ(PULSE_2KHZ),
        .RX_FIFO_RD(RX_FIFO_RD), .RX_FIFO_DATA(RX_FIFO_DATA), .RX_FIFO_EMPTY(RX_FIFO_EMPTY),
        .M_ADDR(M_ADDR), .M_DO(M_DO), .M_DI(M_DI), .M_WE(M_WE), .M_RE(M_RE), .M_XFERACK(M_XFERACK),
        .RSP_VALID(RSP_VALID), .RSP_ADDR(RSP_ADDR), .RSP_DATA(RSP_DATA),
        .FRAME_OK(FRAME_OK), .ERROR_FLAG(ERROR_FLAG), .ERR_CNT(ERR_CNT)
    );

    // FIFO model: data valid the cycle after the read strobe
    logic [7:0] fifo[$];
    always @(posedge OPB_CLK) begin
        if (RX_FIFO_RD && fifo.size() > 0) RX_FIFO_DATA <= fifo.pop_front();
        RX_FIFO_EMPTY <= fifo.size() == 0;
    end

    // OPB slave model: ack arrives in request cycle ack_dly+1
    int ack_dly = 3;
    bit ack_en = 1'b1;
    int ack_n = 0;
    always @(posedge OPB_CLK) begin
        if (M_XFERACK) begin
            M_XFERACK <= 1'b0;
            ack_n = 0;
        end else if ((M_WE || M_RE) && ack_en) begin
            if (ack_n == ack_dly - 1) M_XFERACK <= 1'b1;
            ack_n++;
        end else ack_n = 0;
    end

    int ok_cnt = 0, err_cnt = 0, we_cnt = 0, re_cnt = 0, rsp_cnt = 0, re_hi = 0, both_hi = 0;
    logic [31:0] cap_addr = 0, cap_do = 0;
    always @(negedge OPB_CLK) begin
        if (FRAME_OK) ok_cnt++;
        if (ERROR_FLAG) err_cnt++;
        if (RSP_VALID) rsp_cnt++;
        if (M_RE) re_hi++;
        if (M_WE && M_RE) both_hi++;
        if (M_XFERACK && M_WE) begin
            we_cnt++;
            cap_addr = M_ADDR;
            cap_do = M_DO;
        end
        if (M_XFERACK && M_RE) begin
            re_cnt++;
            cap_addr = M_ADDR;
        end
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_frame(input logic [7:0] b [12], input int len, input int lim);
        int o0, e0;
        o0 = ok_cnt;
        e0 = err_cnt;
        for (int i = 0; i < len; i++) fifo.push_back(b[i]);
        for (int i = 0; i < lim && ok_cnt == o0 && err_cnt == e0; i++) @(posedge OPB_CLK);
        chk("frame_end_seen", 64'(ok_cnt != o0 || err_cnt != e0), 64'd1);
        repeat (3) @(posedge OPB_CLK);
    endtask

    task automatic tick();
        @(posedge OPB_CLK) #1 PULSE_2KHZ = 1'b1;
        @(posedge OPB_CLK) #1 PULSE_2KHZ = 1'b0;
    endtask

    typedef struct {
        int len;
        logic [7:0] b [12];
        logic [31:0] di;
        int ok, err, we, re, rsp;
        logic [31:0] addr, dout;
        logic [7:0] ecnt;
    } vec_t;
    vec_t v [5];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] f [12];
        int o0, e0, w0, r0, s0, h0;
        v[0] = '{10, '{8'h5A,8'h00,8'h00,8'h10,8'h04,8'hDE,8'hAD,8'hBE,8'hEF,8'hA5,8'h00,8'h00},
                 32'h0, 1, 0, 1, 0, 0, 32'h00001004, 32'hDEADBEEF, 8'd0};
        v[1] = '{10, '{8'h5B,8'h00,8'h00,8'h20,8'h00,8'h00,8'h00,8'h00,8'h00,8'hA4,8'h00,8'h00},
                 32'h12345678, 1, 0, 0, 1, 1, 32'h00002000, 32'h0, 8'd0};
        v[2] = '{12, '{8'hFF,8'h00,8'h5A,8'h00,8'h00,8'h00,8'h08,8'h00,8'h00,8'h00,8'h55,8'hA5},
                 32'h0, 1, 0, 1, 0, 0, 32'h00000008, 32'h00000055, 8'd0};
        v[3] = '{10, '{8'h5A,8'h00,8'h00,8'h00,8'h0C,8'h11,8'h22,8'h33,8'h44,8'hA4,8'h00,8'h00},
                 32'h0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 8'd1};
        v[4] = '{10, '{8'h5B,8'h00,8'h00,8'h00,8'h0C,8'h11,8'h22,8'h33,8'h44,8'hA4,8'h00,8'h00},
                 32'hCAFEF00D, 1, 0, 0, 1, 1, 32'h0000000C, 32'h0, 8'd1};

        repeat (3) @(posedge OPB_CLK);
        #1;
        chk("rst_ctrl", {RX_FIFO_RD, M_WE, M_RE, RSP_VALID, FRAME_OK, ERROR_FLAG, ERR_CNT}, 64'd0);
        chk("rst_m_addr", M_ADDR, 0);
        chk("rst_rsp_data", RSP_DATA, 0);
        @(negedge OPB_CLK) OPB_RST = 1'b0;
        repeat (3) @(posedge OPB_CLK);

        for (int i = 0; i < 5; i++) begin
            o0 = ok_cnt; e0 = err_cnt; w0 = we_cnt; r0 = re_cnt; s0 = rsp_cnt;
            M_DI = v[i].di;
            run_frame(v[i].b, v[i].len, 200);
            chk($sformatf("v%0d frame_ok", i), 64'(ok_cnt - o0), 64'(v[i].ok));
            chk($sformatf("v%0d error", i), 64'(err_cnt - e0), 64'(v[i].err));
            chk($sformatf("v%0d writes", i), 64'(we_cnt - w0), 64'(v[i].we));
            chk($sformatf("v%0d reads", i), 64'(re_cnt - r0), 64'(v[i].re));
            chk($sformatf("v%0d rsp_valid", i), 64'(rsp_cnt - s0), 64'(v[i].rsp));
            chk($sformatf("v%0d err_cnt", i), ERR_CNT, v[i].ecnt);
            if (v[i].we + v[i].re > 0) chk($sformatf("v%0d m_addr", i), cap_addr, v[i].addr);
            if (v[i].we > 0) chk($sformatf("v%0d m_do", i), cap_do, v[i].dout);
            if (v[i].rsp > 0) begin
                chk($sformatf("v%0d rsp_addr", i), RSP_ADDR, v[i].addr);
                chk($sformatf("v%0d rsp_data", i), RSP_DATA, v[i].di);
            end
        end

        // byte timeout after three address bytes: 199 ticks harmless, 200th aborts
        f = '{8'h5A,8'h00,8'h00,8'h10,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        e0 = err_cnt;
        for (int i = 0; i < 4; i++) fifo.push_back(f[i]);
        repeat (20) @(posedge OPB_CLK);
        repeat (199) tick();
        repeat (3) @(posedge OPB_CLK);
        chk("byte_to_199", 64'(err_cnt - e0), 64'd0);
        tick();
        repeat (3) @(posedge OPB_CLK);
        chk("byte_to_200", 64'(err_cnt - e0), 64'd1);
        chk("byte_to_err_cnt", ERR_CNT, 8'd2);
        f = '{8'h5A,8'h00,8'h00,8'h00,8'h30,8'h00,8'h00,8'h00,8'h99,8'hA5,8'h00,8'h00};
        o0 = ok_cnt;
        run_frame(f, 10, 200);
        chk("after_to_ok", 64'(ok_cnt - o0), 64'd1);
        chk("after_to_addr", cap_addr, 32'h30);
        chk("after_to_do", cap_do, 32'h99);

        // ack timeout with no acknowledge at all
        ack_en = 1'b0;
        f = '{8'h5B,8'h00,8'h00,8'h00,8'h40,8'h00,8'h00,8'h00,8'h00,8'hA4,8'h00,8'h00};
        o0 = ok_cnt; e0 = err_cnt; h0 = re_hi; s0 = rsp_cnt;
        run_frame(f, 10, 3000);
        chk("ack_to_err", 64'(err_cnt - e0), 64'd1);
        chk("ack_to_no_ok", 64'(ok_cnt - o0), 64'd0);
        chk("ack_to_re_cycles", 64'(re_hi - h0), 64'd1024);
        chk("ack_to_no_rsp", 64'(rsp_cnt - s0), 64'd0);
        chk("ack_to_err_cnt", ERR_CNT, 8'd3);
        chk("ack_to_re_low", M_RE, 0);
        ack_en = 1'b1;

        // ack on the very cycle the timeout expires wins
        ack_dly = 1023;
        M_DI = 32'hA5A5A5A5;
        f = '{8'h5B,8'h00,8'h00,8'h00,8'h44,8'h00,8'h00,8'h00,8'h00,8'hA4,8'h00,8'h00};
        o0 = ok_cnt; e0 = err_cnt; h0 = re_hi; s0 = rsp_cnt;
        run_frame(f, 10, 3000);
        chk("ack_edge_ok", 64'(ok_cnt - o0), 64'd1);
        chk("ack_edge_no_err", 64'(err_cnt - e0), 64'd0);
        chk("ack_edge_re_cycles", 64'(re_hi - h0), 64'd1024);
        chk("ack_edge_rsp", 64'(rsp_cnt - s0), 64'd1);
        chk("ack_edge_rsp_data", RSP_DATA, 32'hA5A5A5A5);
        chk("ack_edge_rsp_addr", RSP_ADDR, 32'h44);
        ack_dly = 3;

        // reset in the middle of the DATA field
        f = '{8'h5A,8'h00,8'h00,8'h00,8'h01,8'h11,8'h22,8'h00,8'h00,8'h00,8'h00,8'h00};
        for (int i = 0; i < 7; i++) fifo.push_back(f[i]);
        repeat (30) @(posedge OPB_CLK);
        @(negedge OPB_CLK) OPB_RST = 1'b1;
        #1;
        chk("mid_rst_ctrl", {RX_FIFO_RD, M_WE, M_RE, RSP_VALID, FRAME_OK, ERROR_FLAG, ERR_CNT}, 64'd0);
        chk("mid_rst_m_addr", M_ADDR, 0);
        chk("mid_rst_m_do", M_DO, 0);
        chk("mid_rst_rsp", {RSP_ADDR, RSP_DATA}, 64'd0);
        @(negedge OPB_CLK) OPB_RST = 1'b0;
        f = '{8'h5A,8'h00,8'h00,8'h00,8'h50,8'h01,8'h02,8'h03,8'h04,8'hA5,8'h00,8'h00};
        o0 = ok_cnt;
        run_frame(f, 10, 200);
        chk("post_rst_ok", 64'(ok_cnt - o0), 64'd1);
        chk("post_rst_do", cap_do, 32'h01020304);
        chk("post_rst_err_cnt", ERR_CNT, 8'd0);

        // reset while a write request is outstanding
        ack_en = 1'b0;
        for (int i = 0; i < 10; i++) fifo.push_back(f[i]);
        for (int i = 0; i < 200 && !M_WE; i++) @(negedge OPB_CLK);
        chk("exec_we_seen", M_WE, 1);
        @(negedge OPB_CLK) OPB_RST = 1'b1;
        #1;
        chk("exec_rst_req", {M_WE, M_RE}, 64'd0);
        @(negedge OPB_CLK) OPB_RST = 1'b0;
        ack_en = 1'b1;
        repeat (3) @(posedge OPB_CLK);
        chk("never_we_and_re", 64'(both_hi), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
